// File: rtl/pipe_mux_sel_pkg.sv
// pipe_mux_sel_pkg: shared constants and helpers for the pipelined multi-way selector.
package pipe_mux_sel_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_INPUTS = 4;
  localparam int unsigned DEF_STAGES = 2;

  // Lane-index width: clog2 of the lane count, but never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned inputs);
    return (inputs <= 2) ? 1 : $clog2(inputs);
  endfunction

  // Bit offset of lane 'lane' inside the packed data bus.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pipe_mux_sel_stage.sv
// pipe_mux_sel_stage: one elastic register slot (valid bit plus data word).
// The data word is only written from a valid source, so it keeps its last
// good value (or RESET_VAL) while bubbles pass through.
module pipe_mux_sel_stage #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Slot register: capture upstream valid on load, data only when it is valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (load) begin
      valid <= src_valid;
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/pipe_mux_sel.sv
// pipe_mux_sel: INPUTS-way, WIDTH-bit selector feeding a STAGES-deep elastic
// pipeline with valid/ready handshake. Out-of-range sel yields RESET_VAL.
// Optional: define PIPE_MUX_SEL_ERR_EN to add the sticky 'err' output that
// flags any accepted transfer whose sel is out of range.
module pipe_mux_sel
  import pipe_mux_sel_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      INPUTS    = DEF_INPUTS,
  parameter int unsigned      STAGES    = DEF_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [sel_width(INPUTS)-1:0]  sel,
  input  logic [INPUTS*WIDTH-1:0]       data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              y
`ifdef PIPE_MUX_SEL_ERR_EN
  ,
  output logic                          err
`endif
);

  localparam int unsigned SW = sel_width(INPUTS);

  logic [WIDTH-1:0]  mux_out;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES:0]   ready;

  // Lane selector; anything past the last lane falls through to RESET_VAL.
  always_comb begin
    mux_out = RESET_VAL;
    for (int unsigned k = 0; k < INPUTS; k++) begin
      if (sel == SW'(k)) begin
        mux_out = data[lane_lsb(k, WIDTH) +: WIDTH];
      end
    end
  end

  // Ready chain from the consumer back to stage 0: a stage may load when it
  // is empty or the stage after it is loading. Built through a running
  // accumulator so no bit of 'ready' is read back within the same block.
  always_comb begin
    logic acc;
    ready         = '0;
    acc           = out_ready;
    ready[STAGES] = acc;
    for (int unsigned j = 0; j < STAGES; j++) begin
      acc                  = !v[STAGES-1-j] | acc;
      ready[STAGES-1-j]    = acc;
    end
  end

  assign in_ready  = ready[0] & ~reset;
  assign out_valid = v[STAGES-1];
  assign y         = d[STAGES-1];

  genvar i;
  generate
    for (i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_first
        pipe_mux_sel_stage #(
          .WIDTH     (WIDTH),
          .RESET_VAL (RESET_VAL)
        ) u_stage (
          .clock     (clock),
          .reset     (reset),
          .load      (ready[0]),
          .src_valid (in_valid),
          .src_data  (mux_out),
          .valid     (v[0]),
          .data      (d[0])
        );
      end else begin : g_rest
        pipe_mux_sel_stage #(
          .WIDTH     (WIDTH),
          .RESET_VAL (RESET_VAL)
        ) u_stage (
          .clock     (clock),
          .reset     (reset),
          .load      (ready[i]),
          .src_valid (v[i-1]),
          .src_data  (d[i-1]),
          .valid     (v[i]),
          .data      (d[i])
        );
      end
    end
  endgenerate

`ifdef PIPE_MUX_SEL_ERR_EN
  logic sel_oob;
  assign sel_oob = (32'(sel) >= INPUTS);

  // Sticky flag: set on any accepted transfer with an out-of-range lane index.
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (in_valid && in_ready && sel_oob) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_mux_sel.sv
// tb_pipe_mux_sel: directed checks of pipe_mux_sel in three configurations
// (8x4x2, 1x2x1 boolean mux, 8x3x2 with out-of-range lane).
module tb_pipe_mux_sel;

  logic clock;
  logic reset;

  // DUT a: WIDTH=8, INPUTS=4, STAGES=2, RESET_VAL=0
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0]  a_sel;
  logic [31:0] a_data;
  logic [7:0]  a_y;

  // DUT b: WIDTH=1, INPUTS=2, STAGES=1, RESET_VAL=0
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0]  b_sel;
  logic [1:0]  b_data;
  logic [0:0]  b_y;

  // DUT c: WIDTH=8, INPUTS=3, STAGES=2, RESET_VAL=8'hA5
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [1:0]  c_sel;
  logic [23:0] c_data;
  logic [7:0]  c_y;
`ifdef PIPE_MUX_SEL_ERR_EN
  logic        c_err;
`endif

  int unsigned checks = 0;
  int unsigned fails  = 0;

  pipe_mux_sel #(.WIDTH(8), .INPUTS(4), .STAGES(2), .RESET_VAL(8'h00)) u_a (
    .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sel(a_sel), .data(a_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .y(a_y)
`ifdef PIPE_MUX_SEL_ERR_EN
    , .err()
`endif
  );

  pipe_mux_sel #(.WIDTH(1), .INPUTS(2), .STAGES(1), .RESET_VAL(1'b0)) u_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sel(b_sel), .data(b_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .y(b_y)
`ifdef PIPE_MUX_SEL_ERR_EN
    , .err()
`endif
  );

  pipe_mux_sel #(.WIDTH(8), .INPUTS(3), .STAGES(2), .RESET_VAL(8'hA5)) u_c (
    .clock(clock), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sel(c_sel), .data(c_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .y(c_y)
`ifdef PIPE_MUX_SEL_ERR_EN
    , .err(c_err)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b1; a_sel = 2'd1; a_out_ready = 1'b1;
    a_data = {8'h44, 8'h33, 8'h22, 8'h11};
    b_in_valid = 1'b0; b_sel = 1'b0; b_out_ready = 1'b1; b_data = 2'b10;
    c_in_valid = 1'b0; c_sel = 2'd0; c_out_ready = 1'b1;
    c_data = {8'hCC, 8'hBB, 8'hAA};

    // Reset state (a offers a transfer that must be refused)
    tick(); tick();
    check("rst_a_in_ready", a_in_ready, 0);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_y", a_y, 8'h00);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_c_out_valid", c_out_valid, 0);
    check("rst_c_y", c_y, 8'hA5);
`ifdef PIPE_MUX_SEL_ERR_EN
    check("rst_c_err", c_err, 0);
`endif
    a_in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", a_in_ready, 1);

    // Single push, sel=2, latency 2
    a_sel = 2'd2; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check("single_e1_valid", a_out_valid, 0);
    check("single_e1_y", a_y, 8'h00);
    tick();
    check("single_e2_valid", a_out_valid, 1);
    check("single_e2_y", a_y, 8'h33);
    tick();
    check("single_e3_valid", a_out_valid, 0);

    // Stream 0..3 with out_ready high
    a_sel = 2'd0; a_in_valid = 1'b1;
    tick();
    a_sel = 2'd1; #1;
    check("stream_in_ready0", a_in_ready, 1);
    tick();
    check("stream_y0", a_y, 8'h11);
    check("stream_v0", a_out_valid, 1);
    a_sel = 2'd2; #1;
    check("stream_in_ready1", a_in_ready, 1);
    tick();
    check("stream_y1", a_y, 8'h22);
    a_sel = 2'd3;
    tick();
    check("stream_y2", a_y, 8'h33);
    a_in_valid = 1'b0;
    tick();
    check("stream_y3", a_y, 8'h44);
    check("stream_v3", a_out_valid, 1);
    tick();
    check("stream_end_valid", a_out_valid, 0);

    // Same stream with the consumer stalled
    a_out_ready = 1'b0; a_sel = 2'd0; a_in_valid = 1'b1;
    tick();
    a_sel = 2'd1; #1;
    check("stall_in_ready1", a_in_ready, 1);
    tick();
    a_sel = 2'd2; #1;
    check("stall_full_in_ready", a_in_ready, 0);
    check("stall_y_first", a_y, 8'h11);
    tick();
    check("stall_hold_y", a_y, 8'h11);
    check("stall_hold_valid", a_out_valid, 1);
    check("stall_hold_in_ready", a_in_ready, 0);
    a_out_ready = 1'b1; #1;
    check("popush_in_ready", a_in_ready, 1);
    tick();
    check("resume_y1", a_y, 8'h22);
    a_sel = 2'd3;
    tick();
    check("resume_y2", a_y, 8'h33);
    a_in_valid = 1'b0;
    tick();
    check("resume_y3", a_y, 8'h44);
    tick();
    check("resume_end_valid", a_out_valid, 0);

    // Boolean-mux regression on b
    b_sel = 1'b0; b_in_valid = 1'b1;
    tick();
    check("bool_sel0_valid", b_out_valid, 1);
    check("bool_sel0_y", b_y, 0);
    b_sel = 1'b1;
    tick();
    check("bool_sel1_y", b_y, 1);
    check("bool_sel1_valid", b_out_valid, 1);
    b_in_valid = 1'b0;
    tick();
    check("bool_end_valid", b_out_valid, 0);

    // Out-of-range lane on c (INPUTS=3)
    c_sel = 2'd1; c_in_valid = 1'b1;
    tick();
`ifdef PIPE_MUX_SEL_ERR_EN
    check("oob_err_before", c_err, 0);
`endif
    c_sel = 2'd3;
    tick();
    c_in_valid = 1'b0;
    check("oob_inrange_y", c_y, 8'hBB);
`ifdef PIPE_MUX_SEL_ERR_EN
    check("oob_err_set", c_err, 1);
`endif
    tick();
    check("oob_y", c_y, 8'hA5);
    check("oob_valid", c_out_valid, 1);
    tick();
    check("oob_end_valid", c_out_valid, 0);
`ifdef PIPE_MUX_SEL_ERR_EN
    check("oob_err_held", c_err, 1);
`endif

    // Reset with two results in flight on a
    a_sel = 2'd0; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_sel = 2'd1;
    tick();
    check("flight_y", a_y, 8'h11);
    a_in_valid = 1'b0;
    reset = 1'b1; #1;
    check("midrst_in_ready", a_in_ready, 0);
    tick();
    check("midrst_valid", a_out_valid, 0);
    check("midrst_y", a_y, 8'h00);
`ifdef PIPE_MUX_SEL_ERR_EN
    check("midrst_err", c_err, 0);
`endif
    reset = 1'b0;
    a_sel = 2'd3; a_in_valid = 1'b1; #1;
    check("after_rst_in_ready", a_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
    check("after_rst_e1_valid", a_out_valid, 0);
    tick();
    check("after_rst_y", a_y, 8'h44);
    check("after_rst_valid", a_out_valid, 1);
    tick();
    check("after_rst_end_valid", a_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
